cpu_hazard_ctrl: RTL and testbench
==================================

// Module: cpu_hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the integer register file. Generates p2 bypass selects,
//  load-use and scoreboard interlocks, and arbitrates the single p4 write port between the
//  main pipe and the multi-cycle divider. Sits beside cpu_regfile; drives its bypass/reg_d inputs.
// PARAMETERS
//  NREG      32   architectural registers (r0 hard-wired zero)
//  RW        5    register index width, $clog2(NREG)
// PORTS
//  clock         in   1   system clock
//  resetn        in   1   asynchronous active-low reset
//  stall         in   1   global freeze (memory wait); all state holds when 1
//  p2_valid      in   1   instruction present in p2
//  p2_reg_a/b    in   RW  source indices; p2_uses_a/b in 1 source actually read
//  p2_reg_d      in   RW  destination index (0 = none)
//  p2_is_load    in   1   p2 is a load (result ready in p4 only)
//  p2_is_div     in   1   p2 issues to divider
//  div_busy      in   1   divider cannot accept
//  div_wb_req    in   1   divider result waiting; div_wb_reg in RW its destination
//  div_start     out  1   one-cycle issue pulse to divider
//  div_wb_ack    out  1   result consumed; divider may drop req
//  p2_hold       out  1   hold p1/p2, bubble into p3
//  p2_bypass_a3/b3/a4/b4 out 1  bypass selects to regfile
//  p4_reg_d      out  RW  writeback index; p4_sel_div out 1 p4_out mux selects divider
// BEHAVIOUR
//  Reset: all outputs 0, p3/p4 tracking regs 0, pending scoreboard 0. Async assert, sync use.
//  Tracking regs p3_reg_d, p3_is_load, p3_div_slot, p4_reg_d, p4_sel_div advance on clock
//   when !stall; bubble loads p3_reg_d=0, p3_is_load=0.
//  Bypass (comb): a3 = uses_a & reg_a!=0 & reg_a==p3_reg_d & !p3_is_load;
//   a4 = uses_a & reg_a!=0 & reg_a==p4_reg_d & !a3. Same for b. a3 priority over a4.
//  p2_hold (comb) when p2_valid and any of:
//   load-use: source == p3_reg_d (nonzero) & p3_is_load;
//   scoreboard: pending[src] for a used source, or pending[p2_reg_d] (WAW);
//   structural: p2_is_div & (div_busy | any pending);
//   writeback: div_wb_req & !p3_div_slot & !p4_sel_div (reserve slot, no p2_valid needed).
//  Div issue: p2_valid & p2_is_div & !p2_hold & !stall -> div_start=1 one cycle;
//   pending[p2_reg_d] set at edge (unless reg_d=0); div instr itself advances as bubble (reg_d 0).
//  Div writeback: reserving cycle loads p3_div_slot=1; next advance moves it to p4:
//   p4_sel_div=1, p4_reg_d=div_wb_reg, div_wb_ack=1 that cycle (registered, gated by !stall);
//   pending[div_wb_reg] clears at that edge. Divider holds req/data/reg until ack.
//  Simultaneous: load-use + wb reservation -> single bubble, used as div slot.
//   Issue and clear of same index same edge cannot occur (WAW hold). r0 never pending.
//  Stall: no pulses (div_start, div_wb_ack forced 0), no scoreboard change, holds combinational.
//  Reset mid-op: scoreboard and slot cleared; divider must also reset (shares resetn).
// CONFIGURATION
//  CPU_HAZARD_PERF_EN defined: adds outputs perf_hold_cnt[31:0] (cycles p2_hold & !stall) and
//   perf_div_cnt[31:0] (div_start pulses), wrap at 2^32, reset 0.
//  Undefined: ports and counters absent; no other change.
// STRUCTURE
//  cpu_pkg: RW/NREG constants, REG_ZERO, typedef reg_idx_t.
//  Sub-module cpu_scoreboard: NREG-bit pending vector, set/clear ports, two read + one WAW
//   lookup; bit0 tied 0.
// TESTING
//  p3 ADD r5, p2 reads r5 -> p2_bypass_a3=1, p2_hold=0.
//  p3 LOAD r7, p2 reads r7 on b -> p2_hold=1 one cycle, then p2_bypass_b4=1.
//  DIV r9 issued; p2 reads r9 -> hold until div_wb_ack edge; p2_reg_d=r9 also held.
//  div_wb_req reg 12 -> bubble, 2 cycles later p4_sel_div=1, p4_reg_d=12, ack pulse 1 cycle.
//  stall=1 during reservation -> no ack, state frozen; resume completes identically.
//  resetn low with pending r3 set -> pending clear, outputs 0; src r0 never bypasses or holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared register-file constants and types for the integer pipeline.
package cpu_pkg;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef logic [RW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/cpu_hazard_ctrl_if.sv
// Pipeline/divider <-> hazard controller signal bundle.
// valid/ready: div_start is a single-cycle issue pulse, only raised while div_busy is low;
// div_wb_req stays high with div_wb_reg stable until div_wb_ack is seen at a clock edge.
interface cpu_hazard_ctrl_if;
  import cpu_pkg::*;

  logic     stall;
  logic     p2_valid;
  reg_idx_t p2_reg_a;
  reg_idx_t p2_reg_b;
  logic     p2_uses_a;
  logic     p2_uses_b;
  reg_idx_t p2_reg_d;
  logic     p2_is_load;
  logic     p2_is_div;
  logic     div_busy;
  logic     div_wb_req;
  reg_idx_t div_wb_reg;
  logic     div_start;
  logic     div_wb_ack;
  logic     p2_hold;
  logic     p2_bypass_a3;
  logic     p2_bypass_b3;
  logic     p2_bypass_a4;
  logic     p2_bypass_b4;
  reg_idx_t p4_reg_d;
  logic     p4_sel_div;

  modport master (
    output stall, p2_valid, p2_reg_a, p2_reg_b, p2_uses_a, p2_uses_b, p2_reg_d,
           p2_is_load, p2_is_div, div_busy, div_wb_req, div_wb_reg,
    input  div_start, div_wb_ack, p2_hold, p2_bypass_a3, p2_bypass_b3,
           p2_bypass_a4, p2_bypass_b4, p4_reg_d, p4_sel_div
  );

  modport slave (
    input  stall, p2_valid, p2_reg_a, p2_reg_b, p2_uses_a, p2_uses_b, p2_reg_d,
           p2_is_load, p2_is_div, div_busy, div_wb_req, div_wb_reg,
    output div_start, div_wb_ack, p2_hold, p2_bypass_a3, p2_bypass_b3,
           p2_bypass_a4, p2_bypass_b4, p4_reg_d, p4_sel_div
  );
endinterface

// File: rtl/cpu_scoreboard.sv
// Pending-write vector for divider destinations; r0 is never pending.
module cpu_scoreboard
  import cpu_pkg::*;
(
  input  logic     clock,
  input  logic     resetn,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rd_a_idx,
  input  reg_idx_t rd_b_idx,
  input  reg_idx_t waw_idx,
  output logic     pend_a,
  output logic     pend_b,
  output logic     pend_d,
  output logic     any_pend
);
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_nxt;

  always_comb begin
    pend_nxt = pend_q;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pend_q <= '0;
    else         pend_q <= pend_nxt;
  end

  assign pend_a   = pend_q[rd_a_idx];
  assign pend_b   = pend_q[rd_b_idx];
  assign pend_d   = pend_q[waw_idx];
  assign any_pend = |pend_q;
endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Bypass select, load-use/scoreboard interlock and p4 write-port arbitration.
// Optional CPU_HAZARD_PERF_EN adds hold-cycle and divider-issue counters.
module cpu_hazard_ctrl
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  cpu_hazard_ctrl_if.slave   hz
`ifdef CPU_HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_hold_cnt,
  output logic [31:0]        perf_div_cnt
`endif
);
  reg_idx_t p3_reg_d;
  logic     p3_is_load;
  logic     p3_div_slot;
  reg_idx_t p4_reg_d_q;
  logic     p4_sel_div_q;

  logic pend_a, pend_b, pend_d, any_pend;
  logic src_a_ok, src_b_ok;
  logic ld_use, sb_hold, struct_hold, wb_reserve, hold;
  logic div_issue, p3_bubble, a3, b3;

  always_comb begin
    src_a_ok    = hz.p2_uses_a && (hz.p2_reg_a != REG_ZERO);
    src_b_ok    = hz.p2_uses_b && (hz.p2_reg_b != REG_ZERO);
    a3          = src_a_ok && (hz.p2_reg_a == p3_reg_d) && !p3_is_load;
    b3          = src_b_ok && (hz.p2_reg_b == p3_reg_d) && !p3_is_load;
    ld_use      = p3_is_load && (p3_reg_d != REG_ZERO) &&
                  ((src_a_ok && hz.p2_reg_a == p3_reg_d) ||
                   (src_b_ok && hz.p2_reg_b == p3_reg_d));
    sb_hold     = (hz.p2_uses_a && pend_a) || (hz.p2_uses_b && pend_b) || pend_d;
    struct_hold = hz.p2_is_div && (hz.div_busy || any_pend);
    // Claim a p3 bubble for the divider only once; the slot in flight blocks re-reservation.
    wb_reserve  = hz.div_wb_req && !p3_div_slot && !p4_sel_div_q;
    hold        = wb_reserve || (hz.p2_valid && (ld_use || sb_hold || struct_hold));
    div_issue   = hz.p2_valid && hz.p2_is_div && !hold && !hz.stall;
    p3_bubble   = !hz.p2_valid || hold || hz.p2_is_div;
  end

  assign hz.p2_hold      = hold;
  assign hz.div_start    = div_issue;
  assign hz.p2_bypass_a3 = a3;
  assign hz.p2_bypass_b3 = b3;
  assign hz.p2_bypass_a4 = src_a_ok && (hz.p2_reg_a == p4_reg_d_q) && !a3;
  assign hz.p2_bypass_b4 = src_b_ok && (hz.p2_reg_b == p4_reg_d_q) && !b3;
  assign hz.p4_reg_d     = p4_reg_d_q;
  assign hz.p4_sel_div   = p4_sel_div_q;
  // The ack cycle is exactly the cycle the divider owns p4; a stall suppresses the pulse.
  assign hz.div_wb_ack   = p4_sel_div_q && !hz.stall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p3_reg_d     <= REG_ZERO;
      p3_is_load   <= 1'b0;
      p3_div_slot  <= 1'b0;
      p4_reg_d_q   <= REG_ZERO;
      p4_sel_div_q <= 1'b0;
    end else if (!hz.stall) begin
      p3_reg_d     <= p3_bubble ? REG_ZERO : hz.p2_reg_d;
      p3_is_load   <= p3_bubble ? 1'b0 : hz.p2_is_load;
      p3_div_slot  <= wb_reserve;
      p4_reg_d_q   <= p3_div_slot ? hz.div_wb_reg : p3_reg_d;
      p4_sel_div_q <= p3_div_slot;
    end
  end

  cpu_scoreboard u_sb (
    .clock    (clock),
    .resetn   (resetn),
    .set_en   (div_issue),
    .set_idx  (hz.p2_reg_d),
    .clr_en   (p3_div_slot && !hz.stall),
    .clr_idx  (hz.div_wb_reg),
    .rd_a_idx (hz.p2_reg_a),
    .rd_b_idx (hz.p2_reg_b),
    .waw_idx  (hz.p2_reg_d),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .pend_d   (pend_d),
    .any_pend (any_pend)
  );

`ifdef CPU_HAZARD_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_hold_cnt <= '0;
      perf_div_cnt  <= '0;
    end else begin
      if (hold && !hz.stall) perf_hold_cnt <= perf_hold_cnt + 32'd1;
      if (div_issue)         perf_div_cnt  <= perf_div_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed-vector bench for cpu_hazard_ctrl: bypass, load-use, divider scoreboard/writeback, stall, reset.
module tb_cpu_hazard_ctrl;
  import cpu_pkg::*;

  logic clock;
  logic resetn;
  int   n_vec  = 0;
  int   n_miss = 0;

  cpu_hazard_ctrl_if hz ();

`ifdef CPU_HAZARD_PERF_EN
  logic [31:0] perf_hold_cnt;
  logic [31:0] perf_div_cnt;
`endif

  cpu_hazard_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .hz     (hz.slave)
`ifdef CPU_HAZARD_PERF_EN
    ,
    .perf_hold_cnt (perf_hold_cnt),
    .perf_div_cnt  (perf_div_cnt)
`endif
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_p2(input logic v, input logic [4:0] a, input logic ua,
                        input logic [4:0] b, input logic ub, input logic [4:0] d,
                        input logic ld, input logic dv);
    hz.p2_valid   = v;
    hz.p2_reg_a   = a;
    hz.p2_uses_a  = ua;
    hz.p2_reg_b   = b;
    hz.p2_uses_b  = ub;
    hz.p2_reg_d   = d;
    hz.p2_is_load = ld;
    hz.p2_is_div  = dv;
  endtask

  task automatic idle_p2();
    set_p2(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wb_req(input logic r, input logic [4:0] idx);
    hz.div_wb_req = r;
    hz.div_wb_reg = idx;
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    hz.stall = 1'b0;
    hz.div_busy = 1'b0;
    idle_p2();
    wb_req(1'b0, 5'd0);
    #12;
    check("rst_p4_reg_d", hz.p4_reg_d, 0);
    check("rst_p4_sel",   hz.p4_sel_div, 0);
    check("rst_ack",      hz.div_wb_ack, 0);
    check("rst_hold",     hz.p2_hold, 0);
    check("rst_start",    hz.div_start, 0);
    resetn = 1'b1;
    next_cycle();

    // ALU result bypass from p3 then p4
    set_p2(1, 0, 0, 0, 0, 5, 0, 0);
    next_cycle();                                   // p3=r5
    set_p2(1, 5, 1, 0, 0, 6, 0, 0);
    settle();
    check("alu_a3",   hz.p2_bypass_a3, 1);
    check("alu_a4",   hz.p2_bypass_a4, 0);
    check("alu_hold", hz.p2_hold, 0);
    next_cycle();                                   // p3=r6, p4=r5
    set_p2(1, 5, 1, 6, 1, 0, 0, 0);
    settle();
    check("p4_a4",    hz.p2_bypass_a4, 1);
    check("p4_a3",    hz.p2_bypass_a3, 0);
    check("p3_b3",    hz.p2_bypass_b3, 1);
    check("p4_reg5",  hz.p4_reg_d, 5);

    // load-use interlock on b
    next_cycle();                                   // p3=0, p4=r6
    set_p2(1, 0, 0, 0, 0, 7, 1, 0);
    next_cycle();                                   // p3=LOAD r7, p4=0
    set_p2(1, 0, 0, 7, 1, 8, 0, 0);
    settle();
    check("ld_hold",  hz.p2_hold, 1);
    check("ld_b3",    hz.p2_bypass_b3, 0);
    check("ld_b4",    hz.p2_bypass_b4, 0);
    next_cycle();                                   // p3=bubble, p4=r7
    check("ld_rel",   hz.p2_hold, 0);
    check("ld_b4_go", hz.p2_bypass_b4, 1);

    // r0 never bypasses or holds
    next_cycle();                                   // p3=r8, p4=0
    set_p2(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();                                   // p3=0, p4=r8
    set_p2(1, 0, 1, 0, 1, 0, 0, 0);
    settle();
    check("r0_a3",    hz.p2_bypass_a3, 0);
    check("r0_a4",    hz.p2_bypass_a4, 0);
    check("r0_b3",    hz.p2_bypass_b3, 0);
    check("r0_hold",  hz.p2_hold, 0);

    // divider issue and scoreboard holds
    next_cycle();                                   // p3=0, p4=0
    set_p2(1, 0, 0, 0, 0, 9, 0, 1);
    settle();
    check("div_start", hz.div_start, 1);
    check("div_nohold", hz.p2_hold, 0);
    next_cycle();                                   // r9 pending
    set_p2(1, 9, 1, 0, 0, 10, 0, 0);
    settle();
    check("raw_hold",  hz.p2_hold, 1);
    check("raw_start", hz.div_start, 0);
    set_p2(1, 0, 0, 0, 0, 9, 0, 0);
    settle();
    check("waw_hold",  hz.p2_hold, 1);
    set_p2(1, 0, 0, 0, 0, 11, 0, 1);
    settle();
    check("div2_hold", hz.p2_hold, 1);
    check("div2_start", hz.div_start, 0);
    set_p2(1, 9, 1, 0, 0, 10, 0, 0);
    wb_req(1, 9);
    next_cycle();                                   // p3 div slot
    check("raw_hold2", hz.p2_hold, 1);
    check("raw_ack0",  hz.div_wb_ack, 0);
    check("raw_sel0",  hz.p4_sel_div, 0);
    next_cycle();                                   // divider owns p4, r9 cleared
    check("r9_ack",    hz.div_wb_ack, 1);
    check("r9_sel",    hz.p4_sel_div, 1);
    check("r9_p4reg",  hz.p4_reg_d, 9);
    check("r9_rel",    hz.p2_hold, 0);
    check("r9_a4",     hz.p2_bypass_a4, 1);
    wb_req(0, 0);
    next_cycle();
    idle_p2();
    settle();
    check("r9_ack_end", hz.div_wb_ack, 0);
    check("r9_sel_end", hz.p4_sel_div, 0);

    // writeback reservation without a p2 instruction
    wb_req(1, 12);
    settle();
    check("wb_hold",   hz.p2_hold, 1);
    next_cycle();
    check("wb_hold1",  hz.p2_hold, 0);
    check("wb_sel1",   hz.p4_sel_div, 0);
    next_cycle();
    check("wb_sel2",   hz.p4_sel_div, 1);
    check("wb_reg2",   hz.p4_reg_d, 12);
    check("wb_ack2",   hz.div_wb_ack, 1);
    wb_req(0, 0);
    next_cycle();
    check("wb_ack3",   hz.div_wb_ack, 0);

    // stall across the reservation
    wb_req(1, 13);
    next_cycle();                                   // slot in p3
    hz.stall = 1'b1;
    set_p2(1, 0, 0, 0, 0, 15, 0, 1);
    settle();
    check("st_start",  hz.div_start, 0);
    check("st_ack",    hz.div_wb_ack, 0);
    next_cycle();
    next_cycle();
    check("st_sel",    hz.p4_sel_div, 0);
    hz.stall = 1'b0;
    idle_p2();
    next_cycle();
    check("st_sel_go", hz.p4_sel_div, 1);
    check("st_reg_go", hz.p4_reg_d, 13);
    check("st_ack_go", hz.div_wb_ack, 1);
    hz.stall = 1'b1;
    settle();
    check("st_ack_gate", hz.div_wb_ack, 0);
    check("st_sel_keep", hz.p4_sel_div, 1);
    next_cycle();
    hz.stall = 1'b0;
    settle();
    check("st_ack_late", hz.div_wb_ack, 1);
    wb_req(0, 0);
    next_cycle();
    check("st_ack_end", hz.div_wb_ack, 0);

    // divider busy is a structural hold
    set_p2(1, 0, 0, 0, 0, 16, 0, 1);
    hz.div_busy = 1'b1;
    settle();
    check("busy_hold",  hz.p2_hold, 1);
    check("busy_start", hz.div_start, 0);
    hz.div_busy = 1'b0;
    settle();
    check("free_start", hz.div_start, 1);
    idle_p2();

    // load-use and writeback reservation share one bubble
    next_cycle();
    set_p2(1, 0, 0, 0, 0, 7, 1, 0);
    next_cycle();                                   // p3=LOAD r7
    set_p2(1, 7, 1, 0, 0, 0, 0, 0);
    wb_req(1, 14);
    settle();
    check("sim_hold",  hz.p2_hold, 1);
    next_cycle();                                   // bubble is the div slot
    check("sim_hold1", hz.p2_hold, 0);
    next_cycle();
    check("sim_sel",   hz.p4_sel_div, 1);
    check("sim_reg",   hz.p4_reg_d, 14);
    wb_req(0, 0);
    idle_p2();
    next_cycle();

    // reset clears a pending destination
    set_p2(1, 0, 0, 0, 0, 3, 0, 1);
    next_cycle();                                   // r3 pending
    set_p2(1, 0, 0, 3, 1, 4, 0, 0);
    settle();
    check("r3_hold",   hz.p2_hold, 1);
    resetn = 1'b0;
    settle();
    check("rst_r3_hold", hz.p2_hold, 0);
    check("rst_r3_p4",   hz.p4_reg_d, 0);
    resetn = 1'b1;
    next_cycle();
    check("post_rst_hold", hz.p2_hold, 0);
    idle_p2();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
